// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, saturating at 10^DIGITS-1.
// Define BIN2BCD_SIGNED_EN to treat BinIn as two's complement and report its sign on Negative.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [BIN_W-1:0]      BinIn,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCDout,
  output logic                  Overflow,
  output logic                  Negative
);

  localparam int BCD_W = 4 * DIGITS;
  // Scratch holds every digit 2^BIN_W can produce, so oversize inputs still shift cleanly.
  localparam int SCR_D = (DIGITS > (BIN_W + 2) / 3) ? DIGITS : (BIN_W + 2) / 3;
  localparam int SCR_W = 4 * SCR_D;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAXV = pow10_m1(DIGITS);

  function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < SCR_D; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] s, input logic ovf);
    logic [BCD_W-1:0] r;
    r = s;
    if (ovf)
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'h9;
    return r;
  endfunction

  logic [1:0]       state;
  logic [BIN_W-1:0] bin_p;
  logic [SCR_W-1:0] scr_p;
  logic [CNT_W-1:0] cnt_p;
  logic             ovf_p;
  logic             neg_p;
  logic [BIN_W-1:0] mag;
  logic             sign;

`ifdef BIN2BCD_SIGNED_EN
  logic signed [BIN_W-1:0] bin_s;
  assign bin_s = $signed(BinIn);
  // Negating the most negative value wraps to 2^(BIN_W-1), which is its correct unsigned magnitude.
  assign mag  = bin_s[BIN_W-1] ? $unsigned(-bin_s) : BinIn;
  assign sign = BinIn[BIN_W-1];
`else
  assign mag  = BinIn;
  assign sign = 1'b0;
`endif

  assign Busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin_p    <= '0;
      scr_p    <= '0;
      cnt_p    <= '0;
      ovf_p    <= 1'b0;
      neg_p    <= 1'b0;
      BCDout   <= '0;
      Overflow <= 1'b0;
      Negative <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          bin_p <= mag;
          scr_p <= '0;
          cnt_p <= CNT_W'(BIN_W);
          ovf_p <= (64'(mag) > MAXV);
          neg_p <= sign && (mag != '0);
          state <= SHIFT;
        end
        // SHIFT: correct digits first, then move the next binary bit into the scratch
        SHIFT: begin
          {scr_p, bin_p} <= {add3(scr_p), bin_p} << 1;
          cnt_p          <= cnt_p - CNT_W'(1);
          if (cnt_p == CNT_W'(1)) state <= FINISH;
        end
        FINISH: begin
          BCDout   <= saturate(scr_p[BCD_W-1:0], ovf_p);
          Overflow <= ovf_p;
          Negative <= neg_p;
          Done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
